tt_um_logarithmic_afpm: RTL and testbench
=========================================

TT_UM_LOGARITHMIC_AFPM -- requirements
Module: tt_um_logarithmic_afpm

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  design-selected flag; ignored by logic.
REQ-006 ui_in  input  8  operand A byte stream, low byte first.
REQ-007 uio_in  input  8  operand B byte stream, low byte first.
REQ-008 uo_out  output  8  product byte stream, low byte first.
REQ-009 uio_out  output  8  SHALL be constant 0.
REQ-010 uio_oe  output  8  SHALL be constant 0; all uio pins are inputs.

Function
REQ-011 Operands and result SHALL be IEEE-754 binary16: sign[15], exponent[14:10] with bias 15, fraction[9:0].
REQ-012 FSM states SHALL be LOAD_LO, LOAD_HI, COMPUTE, OUT_LO, OUT_HI; each advances unconditionally on every clock edge, and OUT_HI returns to LOAD_LO.
REQ-013 LOAD_LO edge: A[7:0]<=ui_in, B[7:0]<=uio_in.
REQ-014 LOAD_HI edge: A[15:8]<=ui_in, B[15:8]<=uio_in.
REQ-015 COMPUTE edge: the 16-bit result register SHALL be loaded from the combinational multiplier.
REQ-016 uo_out SHALL be registered: result[7:0] during OUT_LO, result[15:8] during OUT_HI, 0x00 otherwise.
REQ-017 Latency: the low byte appears on uo_out 3 edges after the LOAD_LO capture edge; a full transaction takes 5 cycles.
REQ-018 Sign: Sa XOR Sb.
REQ-019 Mitchell mantissa: sum = Fa + Fb (11 bits); carry = sum[10]; result fraction = sum[9:0].
REQ-020 Exponent: E = Ea + Eb - 15 + carry, computed signed, at least 7 bits.
REQ-021 No rounding; fraction truncation only.
REQ-022 If either exponent field is 0 (zero or subnormal), the operand SHALL be treated as zero.
REQ-023 Zero operand with finite other operand -> signed zero {S,15'h0}.
REQ-024 Either operand NaN, or Inf x zero -> 0x7E00.
REQ-025 Inf x finite nonzero, or Inf x Inf -> {S,0x7C00}.
REQ-026 E >= 31 -> {S,0x7C00}.
REQ-027 E <= 0 -> {S,15'h0} (flush to zero).
REQ-028 Input changes outside the LOAD edges SHALL have no effect on the result.

Reset
REQ-029 While rst_n=0: state=LOAD_LO; A, B, result and uo_out = 0; uio_out and uio_oe stay 0.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately; the first edge after release is a LOAD_LO capture.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the FP16 constants: BIAS=15, EXP_MAX=31, QNAN=0x7E00, INF=0x7C00.
REQ-032 The combinational datapath SHALL be one sub-module, fp16_log_mul (inputs a[15:0], b[15:0]; output p[15:0]); the top holds the FSM, byte assembly and output mux.

Verification
REQ-033 A=0x3E00 (1.5), B=0x4200 (3.0): release reset, drive bytes 0x00/0x00 then 0x3E/0x42 -> uo_out 0x00 then 0x44 (0x4400, Mitchell value 4.0).
REQ-034 A=0x3C00, B=0x3C00 -> 0x3C00; A=0xC000, B=0x4000 -> 0xC400.
REQ-035 A=0x0101, B=0x0101 (subnormal) -> 0x0000; A=0x7BFF, B=0x7BFF -> 0x7C00 (overflow).
REQ-036 A=0x7C00, B=0x0000 -> 0x7E00; A=0xFC00, B=0x3C00 -> 0xFC00.
REQ-037 Back-to-back transactions with rst_n pulsed low during LOAD_HI -> uo_out=0 while reset is low, and the next transaction completes correctly.

Source files
------------

// File: rtl/tt_um_logarithmic_afpm_pkg.sv
// Shared types and binary16 constants for the logarithmic (Mitchell) FP16 multiplier.
package tt_um_logarithmic_afpm_pkg;

    typedef enum logic [2:0] {
        LOAD_LO = 3'd0,
        LOAD_HI = 3'd1,
        COMPUTE = 3'd2,
        OUT_LO  = 3'd3,
        OUT_HI  = 3'd4
    } state_e;

    localparam logic [4:0]  BIAS    = 5'd15;
    localparam logic [4:0]  EXP_MAX = 5'd31;
    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] INF     = 16'h7C00;

endpackage

// File: rtl/fp16_log_mul.sv
// Combinational binary16 multiplier using Mitchell's approximation: fractions add
// instead of multiplying, with the fraction carry bumping the exponent.
module fp16_log_mul
    import tt_um_logarithmic_afpm_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    logic              w_sign;
    logic [4:0]        w_ea, w_eb;
    logic [9:0]        w_fa, w_fb;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [10:0]       w_sum;
    logic signed [7:0] w_exp;

    assign w_sign = a[15] ^ b[15];
    assign w_ea   = a[14:10];
    assign w_eb   = b[14:10];
    assign w_fa   = a[9:0];
    assign w_fb   = b[9:0];

    // Subnormals have no hidden one to work with, so they collapse to zero.
    assign w_a_zero = (w_ea == 5'd0);
    assign w_b_zero = (w_eb == 5'd0);
    assign w_a_inf  = (w_ea == EXP_MAX) && (w_fa == 10'd0);
    assign w_b_inf  = (w_eb == EXP_MAX) && (w_fb == 10'd0);
    assign w_a_nan  = (w_ea == EXP_MAX) && (w_fa != 10'd0);
    assign w_b_nan  = (w_eb == EXP_MAX) && (w_fb != 10'd0);

    assign w_sum = {1'b0, w_fa} + {1'b0, w_fb};
    assign w_exp = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb})
                 - $signed({3'b000, BIAS}) + $signed({7'd0, w_sum[10]});

    always_comb begin
        p = {w_sign, w_exp[4:0], w_sum[9:0]};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            p = QNAN;
        end else if (w_a_inf || w_b_inf) begin
            p = {w_sign, INF[14:0]};
        end else if (w_a_zero || w_b_zero) begin
            p = {w_sign, 15'd0};
        end else if (w_exp >= $signed({3'b000, EXP_MAX})) begin
            p = {w_sign, INF[14:0]};
        end else if (w_exp <= 8'sd0) begin
            p = {w_sign, 15'd0};
        end
    end

endmodule

// File: rtl/tt_um_logarithmic_afpm.sv
// Byte-serial FP16 multiplier: two load cycles, one compute cycle, two output cycles.
// state   | meaning
// LOAD_LO | capture low operand bytes
// LOAD_HI | capture high operand bytes
// COMPUTE | latch multiplier result
// OUT_LO  | drive result low byte onto uo_out
// OUT_HI  | drive result high byte onto uo_out
module tt_um_logarithmic_afpm
    import tt_um_logarithmic_afpm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e      r_state, w_next;
    logic [15:0] r_a, r_b, r_result;
    logic [7:0]  r_uo_out, w_uo_next;
    logic [15:0] w_product;
    logic        w_unused;

    assign w_unused = ena;
    assign uio_out  = 8'h00;
    assign uio_oe   = 8'h00;
    assign uo_out   = r_uo_out;

    fp16_log_mul u_mul (
        .a (r_a),
        .b (r_b),
        .p (w_product)
    );

    always_comb begin
        w_next    = LOAD_LO;
        w_uo_next = 8'h00;
        case (r_state)
            LOAD_LO: w_next = LOAD_HI;
            LOAD_HI: w_next = COMPUTE;
            COMPUTE: w_next = OUT_LO;
            OUT_LO: begin
                w_next    = OUT_HI;
                w_uo_next = r_result[7:0];
            end
            OUT_HI: begin
                w_next    = LOAD_LO;
                w_uo_next = r_result[15:8];
            end
            default: w_next = LOAD_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LOAD_LO;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_result <= 16'h0000;
            r_uo_out <= 8'h00;
        end else begin
            r_state  <= w_next;
            r_uo_out <= w_uo_next;
            case (r_state)
                LOAD_LO: begin
                    r_a[7:0] <= ui_in;
                    r_b[7:0] <= uio_in;
                end
                LOAD_HI: begin
                    r_a[15:8] <= ui_in;
                    r_b[15:8] <= uio_in;
                end
                COMPUTE: r_result <= w_product;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_logarithmic_afpm.sv
// Self-checking bench for the byte-serial Mitchell FP16 multiplier.
module tb_tt_um_logarithmic_afpm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    tt_um_logarithmic_afpm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int ea, eb, fa, fb, sum, e;
        logic [15:0] r;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0)) return 16'h7E00;
        if ((ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return 16'h7E00;
        if (ea == 31 || eb == 31) return {s, 15'h7C00};
        if (ea == 0 || eb == 0) return {s, 15'h0000};
        sum = fa + fb;
        e = ea + eb - 15 + (sum >= 1024 ? 1 : 0);
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return {s, 15'h0000};
        r = {s, 5'(e), 10'(sum % 1024)};
        return r;
    endfunction

    // Called on a negedge while the DUT sits in LOAD_LO; returns on the negedge after OUT_HI.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] want);
        logic [15:0] e;
        ui_in = a[7:0]; uio_in = b[7:0];
        exp_q.push_back(want);
        @(posedge clk); @(negedge clk);
        ui_in = a[15:8]; uio_in = b[15:8];
        @(posedge clk); @(negedge clk);
        ui_in = 8'($urandom); uio_in = 8'($urandom);
        check_val("idle_out", {8'h00, uo_out}, 16'h0000);
        @(posedge clk); @(negedge clk);
        ui_in = 8'($urandom); uio_in = 8'($urandom);
        @(posedge clk); @(negedge clk);
        e = exp_q.pop_front();
        check_val("out_lo", {8'h00, uo_out}, {8'h00, e[7:0]});
        ui_in = 8'($urandom); uio_in = 8'($urandom);
        @(posedge clk); @(negedge clk);
        check_val("out_hi", {8'h00, uo_out}, {8'h00, e[15:8]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        repeat (2) @(negedge clk);
        check_val("rst_uo_out", {8'h00, uo_out}, 16'h0000);
        check_val("rst_uio_out", {8'h00, uio_out}, 16'h0000);
        check_val("rst_uio_oe", {8'h00, uio_oe}, 16'h0000);
        rst_n = 1'b1;

        run_txn(16'h3E00, 16'h4200, 16'h4400);
        run_txn(16'h3C00, 16'h3C00, 16'h3C00);
        run_txn(16'hC000, 16'h4000, 16'hC400);
        run_txn(16'h0101, 16'h0101, 16'h0000);
        run_txn(16'h7BFF, 16'h7BFF, 16'h7C00);
        run_txn(16'h7C00, 16'h0000, 16'h7E00);
        run_txn(16'hFC00, 16'h3C00, 16'hFC00);
        run_txn(16'h7C00, 16'hFC00, 16'hFC00);
        run_txn(16'h7C01, 16'h3C00, 16'h7E00);
        run_txn(16'h8000, 16'h3C00, 16'h8000);
        run_txn(16'h0400, 16'h0400, 16'h0000);
        run_txn(16'h3A00, 16'h3A00, 16'h3800);

        // Reset pulsed during LOAD_HI aborts that transaction.
        ui_in = 8'h55; uio_in = 8'hAA;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1 check_val("abort_lohi_uo", {8'h00, uo_out}, 16'h0000);
        @(posedge clk); @(negedge clk);
        check_val("abort_hold_uo", {8'h00, uo_out}, 16'h0000);
        rst_n = 1'b1;
        run_txn(16'h4000, 16'h4000, 16'h4400);

        // Reset while the low result byte is on uo_out must clear it at once.
        ui_in = 8'h00; uio_in = 8'h00;
        repeat (2) begin @(posedge clk); @(negedge clk); ui_in = 8'h3E; uio_in = 8'h42; end
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check_val("pre_abort_lo", {8'h00, uo_out}, 16'h0000);
        rst_n = 1'b0;
        #1 check_val("abort_out_uo", {8'h00, uo_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(16'hC200, 16'h3E00, 16'hC400);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_txn(ra, rb, ref_mul(ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
